clock_divider_scheduler: RTL and testbench
==========================================

# clock_divider_scheduler

Runtime-programmable bank of NUM_CH clock-enable dividers. It replaces fixed-prescaler dividers wherever the rate must change in operation. Each channel produces a one-cycle `tick` strobe and a divided square wave `div_clk`. A single valid/ready configuration port retargets any channel. Updates take effect only on that channel's period boundary, so no runt periods appear. A global `sync` input phase-aligns all channels.

## Interface
- NUM_CH, 3, number of divider channels (1..16)
- DIV_W, 8, divisor width
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (0..2^DIV_W-1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request accepted when `cfg_valid && cfg_ready` at a rising edge
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  DIV_W  new divisor; 0 stops the channel
- sync  in  1  one-cycle pulse: restart all counters at 0
- tick  out  NUM_CH  per-channel strobe; 1 in the last cycle of each period
- div_clk  out  NUM_CH  per-channel divided clock (use as enable/data, not as a clock net)
- pending  out  NUM_CH  channel holds an accepted, not-yet-applied divisor
- cfg_err  out  1  sticky; set when a request with `cfg_ch >= NUM_CH` is accepted

## Operation
- Per-channel state: `div` (active divisor), `cnt` (DIV_W bits), `shadow` (DIV_W bits), `pend` bit.
- Counting for div ≥ 1: `cnt` steps 0, 1, …, div-1, then wraps to 0.
- Decode for div ≥ 1: `tick` = (cnt == div-1); `div_clk` = (cnt < div/2), using floor division.
- div=1: `tick` is constantly 1 and `div_clk` is constantly 0.
- div=0: the channel is stopped; `cnt` holds 0, and `tick` and `div_clk` are 0.
- Outputs are combinational decodes of the registered `cnt` and `div` only; no input feeds an output path.
- cfg_ready = ~pend[cfg_ch] when cfg_ch < NUM_CH, else 1.
- Accept with a valid channel: `shadow` ← cfg_div and `pend` ← 1.
- Accept with an invalid channel: the write is dropped and `cfg_err` ← 1. Only `rst` clears `cfg_err`.
- Apply rule: on the edge where a pending channel has (div ≥ 1 and cnt == div-1) or div == 0, do `div` ← `shadow`, `cnt` ← 0, `pend` ← 0.
- `sync`: every channel gets `cnt` ← 0 on that edge. A pending update whose apply condition is also true on that edge is still applied, and its `cnt` is 0.
- `sync` does not apply updates that are not at a boundary.
- Accept and apply on the same edge are impossible for one channel, because `cfg_ready` is low while `pend` is set.
- Accepts to different channels are independent.
- Reset mid-operation discards all pending updates.

## Timing
- Reset values:
  - div = DEFAULT_DIV, cnt = 0, pend = 0, cfg_err = 0
  - tick = (DEFAULT_DIV == 1)
  - div_clk = (DEFAULT_DIV ≥ 2)
  - cfg_ready = 1, pending = 0
- First edge after `rst` deasserts: cnt = 1 for div ≥ 2.
- Tick period is exactly div cycles. For even div, `div_clk` has a 50 % duty cycle; for odd div, it is high for (div-1)/2 cycles.
- Configuration latency: the new divisor becomes active on the first period boundary at or after the edge following acceptance. The worst case is old_div cycles after acceptance.
- The first new period starts with cnt = 0. The last old period is always complete and ends with its `tick`.
- A stopped channel (div=0) applies its update on the edge after acceptance.

## Structure
- Package `clock_divider_scheduler_pkg` holds DIV_W and DEFAULT_DIV defaults plus the `ch_idx_t` width helper function.
- Sub-module `clock_divider_channel` holds one channel: div/cnt/shadow/pend registers, the apply rule, and the output decode. The top instantiates NUM_CH of them with a generate loop and adds the cfg decode, `cfg_ready` mux, and `cfg_err`.

## Test plan
- Reset with DEFAULT_DIV=2, NUM_CH=3 → every channel ticks every 2 cycles; div_clk toggles every cycle (1,0,1,0); pending=0; cfg_ready=1.
- Write ch0=4, ch1=10, ch2=0 → each change occurs only after the current period's tick. Then ch0 ticks every 4 cycles with div_clk high 2 of 4; ch1 ticks every 10 cycles with div_clk high 5 of 10; ch2 outputs are 0.
- Write ch1=3 early in a div=10 period, then hold cfg_valid for ch1=5 → cfg_ready is low until the div=10 period ends; the first write applies at cnt=9; the second is accepted the next cycle and applies after one full 3-cycle period.
- Stopped ch2 written with 1 → pending for exactly 1 cycle; then tick=1 continuously and div_clk=0.
- With ch0=4 and ch1=10 running, pulse sync while ch0 has an update pending at cnt=1 → both counters read 0 on the next cycle; the pending update is not applied until ch0 next reaches cnt=3.
- Write cfg_ch=3 (NUM_CH=3) → accepted in 1 cycle; no channel changes; cfg_err=1 until rst. Assert rst mid-period with pend set → all channels return to DEFAULT_DIV and pending=0.

Source files
------------

// File: rtl/clock_divider_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_scheduler_pkg
// Purpose  : Shared defaults and the channel-index width helper for the
//            runtime-programmable clock-enable divider bank.
// Revision : 1.0 - initial release
// ============================================================================
package clock_divider_scheduler_pkg;

    localparam int c_div_w_default       = 8;
    localparam int c_default_div_default = 2;

    // Width of a channel index; a single-channel bank still gets one bit
    function automatic int ch_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_channel.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_channel
// Purpose  : One divider channel: active divisor, counter, shadow divisor and
//            pending flag, boundary-only update, and tick/div_clk decode.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_channel
    import clock_divider_scheduler_pkg::*;
#(
    parameter int DIV_W       = c_div_w_default,
    parameter int DEFAULT_DIV = c_default_div_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             div_clk,
    output logic             pending
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pend;

    logic             w_running;
    logic             w_at_end;
    logic             w_apply;
    logic [DIV_W-1:0] w_last;

    assign w_running = (r_div != '0);
    assign w_last    = r_div - DIV_W'(1);
    assign w_at_end  = w_running && (r_cnt == w_last);
    // A stopped channel has no period to finish, so it is always at a boundary
    assign w_apply   = r_pend && (w_at_end || !w_running);

    // Counter, divisor and shadow registers with boundary-only update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= DIV_W'(DEFAULT_DIV);
            r_cnt    <= '0;
            r_shadow <= '0;
            r_pend   <= 1'b0;
        end else if (w_apply) begin
            // Write cannot coincide: the port is not ready while pending
            r_div  <= r_shadow;
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            if (sync || !w_running || w_at_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
            if (wr_en) begin
                r_shadow <= wr_div;
                r_pend   <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only; div=1 gives tick=1, div_clk=0
    assign tick    = w_at_end;
    assign div_clk = w_running && (r_cnt < (r_div >> 1));
    assign pending = r_pend;

endmodule
`default_nettype wire

// File: rtl/clock_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_scheduler
// Purpose  : Bank of NUM_CH runtime-programmable clock-enable dividers with a
//            shared valid/ready configuration port and global phase sync.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_scheduler
    import clock_divider_scheduler_pkg::*;
#(
    parameter int   NUM_CH      = 3,
    parameter int   DIV_W       = c_div_w_default,
    parameter int   DEFAULT_DIV = c_default_div_default,
    localparam int  CH_W        = ch_idx_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] pending,
    output logic              cfg_err
);

    localparam logic [CH_W:0] c_num_ch = CH_W'(NUM_CH) == '0 && NUM_CH > 0
                                         ? {1'b1, {CH_W{1'b0}}}
                                         : {1'b0, CH_W'(NUM_CH)};

    logic              w_ch_valid;
    logic              w_pend_sel;
    logic              w_accept;
    logic [NUM_CH-1:0] w_wr_en;
    logic              r_cfg_err;

    assign w_ch_valid = ({1'b0, cfg_ch} < c_num_ch);

    // Select the pending flag of the addressed channel
    always_comb begin
        w_pend_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_pend_sel = pending[i];
            end
        end
    end

    // Out-of-range requests are always accepted so the port never stalls
    assign cfg_ready = w_ch_valid ? ~w_pend_sel : 1'b1;
    assign w_accept  = cfg_valid && cfg_ready;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_wr_en[g] = w_accept && w_ch_valid && (cfg_ch == CH_W'(g));

            clock_divider_channel #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .sync    (sync),
                .wr_en   (w_wr_en[g]),
                .wr_div  (cfg_div),
                .tick    (tick[g]),
                .div_clk (div_clk[g]),
                .pending (pending[g])
            );
        end
    endgenerate

    // Sticky error flag for accepted writes to a non-existent channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (w_accept && !w_ch_valid) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_scheduler
// Purpose  : Self-checking bench: reset/table vectors, directed corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_scheduler;

    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] pending;
    logic              cfg_err;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: per-channel divisor, position in period, queued divisor
    int m_div [NUM_CH];
    int m_cnt [NUM_CH];
    int m_sh  [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_err;

    typedef struct {
        bit         v;
        int         ch;
        int         d;
        bit [2:0]   tk;
        bit [2:0]   dc;
        bit [2:0]   pd;
        bit         rdy;
    } vec_t;

    vec_t vecs[8];

    clock_divider_scheduler #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .sync      (sync),
        .tick      (tick),
        .div_clk   (div_clk),
        .pending   (pending),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    function automatic bit [2:0] m_tick();
        bit [2:0] r = '0;
        for (int c = 0; c < NUM_CH; c++)
            r[c] = (m_div[c] >= 1) && (m_cnt[c] == m_div[c] - 1);
        return r;
    endfunction

    function automatic bit [2:0] m_dclk();
        bit [2:0] r = '0;
        for (int c = 0; c < NUM_CH; c++)
            r[c] = (m_div[c] >= 1) && (m_cnt[c] < m_div[c] / 2);
        return r;
    endfunction

    function automatic bit [2:0] m_pending();
        bit [2:0] r = '0;
        for (int c = 0; c < NUM_CH; c++) r[c] = m_pend[c];
        return r;
    endfunction

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_edge();
        bit acc;
        acc = cfg_valid && m_ready();
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c] = DEFAULT_DIV; m_cnt[c] = 0; m_sh[c] = 0; m_pend[c] = 0;
            end
            m_err = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                bit boundary;
                boundary = (m_div[c] == 0) || (m_cnt[c] == m_div[c] - 1);
                if (m_pend[c] && boundary) begin
                    m_div[c] = m_sh[c]; m_cnt[c] = 0; m_pend[c] = 0;
                end else begin
                    if (sync || m_div[c] == 0) m_cnt[c] = 0;
                    else m_cnt[c] = (m_cnt[c] + 1) % m_div[c];
                    if (acc && int'(cfg_ch) == c) begin
                        m_sh[c] = cfg_div; m_pend[c] = 1;
                    end
                end
            end
            if (acc && int'(cfg_ch) >= NUM_CH) m_err = 1;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("tick",      32'(tick),      32'(m_tick()));
        chk("div_clk",   32'(div_clk),   32'(m_dclk()));
        chk("pending",   32'(pending),   32'(m_pending()));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
        chk("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    task automatic do_write(input int ch, input int d);
        bit acc = 0;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = DIV_W'(d);
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = m_ready();
            step();
        end
        if (!acc) chk("write_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; sync = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c] = 0; m_cnt[c] = 0; m_sh[c] = 0; m_pend[c] = 0;
        end
        m_err = 0;

        // Hand-derived vectors from reset with DEFAULT_DIV=2 (bit index = channel)
        vecs[0] = '{0, 0, 0, 3'b111, 3'b000, 3'b000, 1};
        vecs[1] = '{0, 0, 0, 3'b000, 3'b111, 3'b000, 1};
        vecs[2] = '{1, 0, 4, 3'b111, 3'b000, 3'b001, 0};
        vecs[3] = '{0, 0, 0, 3'b000, 3'b111, 3'b000, 1};
        vecs[4] = '{0, 0, 0, 3'b110, 3'b001, 3'b000, 1};
        vecs[5] = '{0, 0, 0, 3'b000, 3'b110, 3'b000, 1};
        vecs[6] = '{0, 0, 0, 3'b111, 3'b000, 3'b000, 1};
        vecs[7] = '{0, 0, 0, 3'b000, 3'b111, 3'b000, 1};

        step(); step();
        chk("rst_tick",    32'(tick),      32'(3'b000));
        chk("rst_div_clk", 32'(div_clk),   32'(3'b111));
        chk("rst_pending", 32'(pending),   32'(3'b000));
        chk("rst_ready",   32'(cfg_ready), 32'd1);
        chk("rst_err",     32'(cfg_err),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cfg_valid = vecs[i].v; cfg_ch = 2'(vecs[i].ch); cfg_div = DIV_W'(vecs[i].d);
            step();
            chk("vec_tick",    32'(tick),      32'(vecs[i].tk));
            chk("vec_div_clk", 32'(div_clk),   32'(vecs[i].dc));
            chk("vec_pending", 32'(pending),   32'(vecs[i].pd));
            chk("vec_ready",   32'(cfg_ready), 32'(vecs[i].rdy));
        end
        cfg_valid = 1'b0; cfg_ch = '0;

        // Sync while ch0 holds a pending update at cnt=1
        do_reset();
        do_write(0, 4); do_write(1, 10);
        for (int k = 0; k < 12; k++) step();
        for (int k = 0; k < 20 && !(m_cnt[0] == 0 && !m_pend[0]); k++) step();
        do_write(0, 6);
        chk("sync_pre_cnt1", 32'(m_cnt[0]), 32'd1);
        sync = 1'b1; step(); sync = 1'b0;
        chk("sync_ch0_tick", 32'(tick[0]),    32'd0);
        chk("sync_ch0_dclk", 32'(div_clk[0]), 32'd1);
        chk("sync_ch0_pend", 32'(pending[0]), 32'd1);
        chk("sync_ch1_dclk", 32'(div_clk[1]), 32'd1);
        step(); step(); step();
        chk("sync_ch0_end_tick", 32'(tick[0]),    32'd1);
        chk("sync_ch0_end_pend", 32'(pending[0]), 32'd1);
        step();
        chk("sync_ch0_applied", 32'(pending[0]), 32'd0);

        // Stopped channel receives divisor 1
        do_write(2, 0);
        for (int k = 0; k < 12 && m_pend[2]; k++) step();
        step();
        chk("stop_ch2_tick", 32'(tick[2]),    32'd0);
        chk("stop_ch2_dclk", 32'(div_clk[2]), 32'd0);
        do_write(2, 1);
        chk("div1_pend_set", 32'(pending[2]), 32'd1);
        step();
        chk("div1_pend_clr", 32'(pending[2]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("div1_tick", 32'(tick[2]),    32'd1);
            chk("div1_dclk", 32'(div_clk[2]), 32'd0);
            step();
        end

        // Out-of-range channel, then reset with an update pending
        do_write(3, 5);
        chk("err_set", 32'(cfg_err), 32'd1);
        step(); step();
        chk("err_sticky", 32'(cfg_err), 32'd1);
        do_write(1, 7);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_pending", 32'(pending), 32'(3'b000));
        chk("mid_rst_tick",    32'(tick),    32'(3'b000));
        chk("mid_rst_dclk",    32'(div_clk), 32'(3'b111));
        chk("mid_rst_err",     32'(cfg_err), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = ($urandom_range(0, 5) == 0) ? DIV_W'($urandom_range(0, 1))
                                                    : DIV_W'($urandom_range(2, 12));
            sync      = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        cfg_valid = 1'b0; sync = 1'b0; rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
